// File: rtl/snake_step_ctrl_if.sv
// Signal bundle between the snake movement sequencer and the head-position datapath.
// step is a one-cycle strobe that qualifies x_motion/y_motion (both zero otherwise); there is no back-pressure.
interface snake_step_ctrl_if;
    logic [15:0] keycode;
    logic [9:0]  head_x;
    logic [9:0]  head_y;
    logic        step;
    logic [1:0]  dir;
    logic [9:0]  x_motion;
    logic [9:0]  y_motion;
    logic [1:0]  state;
    logic        game_over;
    logic        restart;

    modport master (
        input  keycode, head_x, head_y,
        output step, dir, x_motion, y_motion, state, game_over, restart
    );

    modport slave (
        output keycode, head_x, head_y,
        input  step, dir, x_motion, y_motion, state, game_over, restart
    );
endinterface

// File: rtl/snake_step_ctrl.sv
// Snake movement sequencer: key press detection, reversal-filtered turn queue,
// frame-based step scheduling with wall collision, and IDLE/RUN/PAUSE/OVER game state.
module snake_step_ctrl #(
    parameter int STEP_FRAMES = 4,
    parameter int STEP_PX     = 1,
    parameter int HEAD_SIZE   = 12,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479
) (
    input  logic              frame_clk,
    input  logic              Reset,
    snake_step_ctrl_if.master bus
);
    localparam int              CNT_W    = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_FRAMES - 1);
    localparam logic [10:0]     MARGIN   = 11'(HEAD_SIZE + STEP_PX);
    localparam logic [10:0]     X_LIM    = 11'(X_MAX);
    localparam logic [10:0]     Y_LIM    = 11'(Y_MAX);
    localparam logic [9:0]      PX_POS   = 10'(STEP_PX);
    localparam logic [9:0]      PX_NEG   = 10'(-STEP_PX);

    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    function automatic logic is_arrow(input logic [7:0] code);
        is_arrow = (code == KEY_UP) || (code == KEY_DOWN) ||
                   (code == KEY_LEFT) || (code == KEY_RIGHT);
    endfunction

    function automatic logic [1:0] key_dir(input logic [7:0] code);
        case (code)
            KEY_UP:   key_dir = DIR_UP;
            KEY_DOWN: key_dir = DIR_DOWN;
            KEY_LEFT: key_dir = DIR_LEFT;
            default:  key_dir = DIR_RIGHT;
        endcase
    endfunction

    // Extended to 11 bits so the down/right sums cannot wrap past 1023.
    function automatic logic hits_wall(input logic [1:0] d, input logic [9:0] hx, input logic [9:0] hy);
        logic [10:0] x11;
        logic [10:0] y11;
        x11 = {1'b0, hx};
        y11 = {1'b0, hy};
        case (d)
            DIR_UP:   hits_wall = y11 < MARGIN;
            DIR_DOWN: hits_wall = (y11 + MARGIN) > Y_LIM;
            DIR_LEFT: hits_wall = x11 < MARGIN;
            default:  hits_wall = (x11 + MARGIN) > X_LIM;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [1:0]       dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0][1:0]  fifo_q, fifo_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic [15:0]      key_prev_q, key_prev_d;
    logic             step_q, step_d;
    logic [9:0]       xm_q, xm_d;
    logic [9:0]       ym_q, ym_d;
    logic             game_over_q, game_over_d;
    logic             restart_q, restart_d;

    logic [1:0][7:0]  slot;
    logic [1:0]       fresh;
    logic [1:0]       arrow_new;
    logic             space_new;
    logic             take_arrows;
    logic [1:0]       ref_dir;
    logic [1:0]       req_dir;

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        cnt_d       = cnt_q;
        fifo_d      = fifo_q;
        fcnt_d      = fcnt_q;
        key_prev_d  = bus.keycode;
        step_d      = 1'b0;
        xm_d        = '0;
        ym_d        = '0;
        restart_d   = 1'b0;
        take_arrows = 1'b0;
        space_new   = 1'b0;
        req_dir     = '0;

        slot[0] = bus.keycode[7:0];
        slot[1] = bus.keycode[15:8];
        for (int s = 0; s < 2; s++) begin
            fresh[s]     = (slot[s] != key_prev_q[7:0]) && (slot[s] != key_prev_q[15:8]);
            arrow_new[s] = fresh[s] && is_arrow(slot[s]);
            if (fresh[s] && (slot[s] == KEY_SPACE)) begin
                space_new = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (space_new) begin
                    state_d = ST_RUN;
                end else if (|arrow_new) begin
                    state_d     = ST_RUN;
                    take_arrows = 1'b1;
                end
            end
            ST_RUN: begin
                if (space_new) begin
                    state_d = ST_PAUSE;
                end else begin
                    take_arrows = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (fcnt_q != 2'd0) begin
                            dir_d     = fifo_q[0];
                            fifo_d[0] = fifo_q[1];
                            fcnt_d    = fcnt_q - 2'd1;
                        end
                        if (hits_wall(dir_d, bus.head_x, bus.head_y)) begin
                            state_d = ST_OVER;
                        end else begin
                            step_d = 1'b1;
                            case (dir_d)
                                DIR_UP:   ym_d = PX_NEG;
                                DIR_DOWN: ym_d = PX_POS;
                                DIR_LEFT: xm_d = PX_NEG;
                                default:  xm_d = PX_POS;
                            endcase
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PAUSE: begin
                if (space_new) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (space_new) begin
                    restart_d = 1'b1;
                    fcnt_d    = '0;
                    dir_d     = DIR_RIGHT;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end
            end
        endcase

        // Pushes see the post-pop queue; an accepted slot0 turn becomes slot1's reference.
        ref_dir = (fcnt_d == 2'd0) ? dir_d : ((fcnt_d == 2'd1) ? fifo_d[0] : fifo_d[1]);
        if (take_arrows) begin
            for (int s = 0; s < 2; s++) begin
                if (arrow_new[s]) begin
                    req_dir = key_dir(slot[s]);
                    if ((req_dir != ref_dir) && (req_dir != (ref_dir ^ 2'b01)) && (fcnt_d != 2'd2)) begin
                        if (fcnt_d == 2'd0) begin
                            fifo_d[0] = req_dir;
                        end else begin
                            fifo_d[1] = req_dir;
                        end
                        fcnt_d  = fcnt_d + 2'd1;
                        ref_dir = req_dir;
                    end
                end
            end
        end

        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_RIGHT;
            cnt_q       <= '0;
            fifo_q      <= '0;
            fcnt_q      <= '0;
            key_prev_q  <= '0;
            step_q      <= 1'b0;
            xm_q        <= '0;
            ym_q        <= '0;
            game_over_q <= 1'b0;
            restart_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            fifo_q      <= fifo_d;
            fcnt_q      <= fcnt_d;
            key_prev_q  <= key_prev_d;
            step_q      <= step_d;
            xm_q        <= xm_d;
            ym_q        <= ym_d;
            game_over_q <= game_over_d;
            restart_q   <= restart_d;
        end
    end

    assign bus.step      = step_q;
    assign bus.dir       = dir_q;
    assign bus.x_motion  = xm_q;
    assign bus.y_motion  = ym_q;
    assign bus.state     = state_q;
    assign bus.game_over = game_over_q;
    assign bus.restart   = restart_q;
endmodule
